// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  // Also flags the illegal size, so one test covers every error case.
  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = addr_lo[0];
      WORD:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_store_merge.sv
// Combinational byte/halfword lane merge of store data into an existing word.
module mem_store_merge
  import mem_arb_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] old_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  size_e             size_i,
  input  logic [1:0]        addr_lo_i,
  output logic [DWIDTH-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (size_i)
      BYTE:    merged_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      HALF:    merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin fetch/load-store arbiter in front of a word memory, with
// read-modify-write for byte and halfword stores.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       AWIDTH    = 32,
  parameter int unsigned       DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_size_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  if (DWIDTH != 32 || BASE_ADDR[1:0] != 2'b00) begin : g_cfg_err
    $error("mem_arbiter: DWIDTH must be 32 and BASE_ADDR word aligned");
  end

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;  // 1: data side was granted most recently
  logic [AWIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic [DWIDTH-1:0] rmw_data_q, rmw_data_d;
  logic              if_rvalid_q, d_rvalid_q, d_err_q;
  logic [DWIDTH-1:0] if_rdata_q, d_rdata_q;

  size_e             d_size;
  logic              d_bad;
  logic [AWIDTH-1:0] if_addr_al, d_addr_al;
  logic [DWIDTH-1:0] merged;
  logic              d_resp, d_resp_err, d_resp_load;

  assign d_size     = size_e'(d_size_i);
  assign d_bad      = misaligned(d_size, d_addr_i[1:0]);
  assign if_addr_al = if_addr_i & ~AWIDTH'(3);
  assign d_addr_al  = d_addr_i & ~AWIDTH'(3);

  mem_store_merge #(.DWIDTH(DWIDTH)) u_merge (
    .old_i     (mem_data_i),
    .wdata_i   (d_wdata_i),
    .size_i    (d_size),
    .addr_lo_i (d_addr_i[1:0]),
    .merged_o  (merged)
  );

  always_comb begin
    state_d        = state_q;
    last_d_d       = last_d_q;
    rmw_addr_d     = rmw_addr_q;
    rmw_data_d     = rmw_data_q;
    if_gnt_o       = 1'b0;
    d_gnt_o        = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    d_resp         = 1'b0;
    d_resp_err     = 1'b0;
    d_resp_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i && (!d_req_i || last_d_q)) begin
          if_gnt_o      = 1'b1;
          last_d_d      = 1'b0;
          mem_addr_o    = if_addr_al;
          mem_read_en_o = 1'b1;
        end else if (d_req_i) begin
          d_gnt_o    = 1'b1;
          last_d_d   = 1'b1;
          mem_addr_o = d_addr_al;
          if (d_bad) begin
            d_resp     = 1'b1;
            d_resp_err = 1'b1;
          end else if (!d_we_i) begin
            mem_read_en_o = 1'b1;
            d_resp        = 1'b1;
            d_resp_load   = 1'b1;
          end else if (d_size == WORD) begin
            mem_data_o     = d_wdata_i;
            mem_write_en_o = 1'b1;
            d_resp         = 1'b1;
          end else begin
            mem_read_en_o = 1'b1;
            rmw_addr_d    = d_addr_al;
            rmw_data_d    = merged;
            state_d       = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_addr_o     = rmw_addr_q;
        mem_data_o     = rmw_data_q;
        mem_write_en_o = 1'b1;
        d_resp         = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset overrides here so an in-flight RMW write never reaches memory.
    if (rst) begin
      if_gnt_o       = 1'b0;
      d_gnt_o        = 1'b0;
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      rmw_addr_q  <= '0;
      rmw_data_q  <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_data_q  <= rmw_data_d;
      if_rvalid_q <= if_gnt_o;
      if (if_gnt_o) if_rdata_q <= mem_data_i;
      d_rvalid_q  <= d_resp;
      d_err_q     <= d_resp_err;
      if (d_resp) d_rdata_q <= d_resp_load ? mem_data_i : '0;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_err_o     = d_err_q;
  assign d_rdata_o   = d_rdata_q;

endmodule
